id_stage_pipelined: RTL and testbench
=====================================

// Module: id_stage_pipelined
// PURPOSE
//  Next-generation decode stage. Combines a register file with write-through reads,
//  NUM_FWD-source priority forwarding, load-use hazard detection and a registered
//  ID/EX pipeline register with flush and stall controls.
//  Sits between the IF/ID register and the execute stage. Owns the bubble/stall decision
//  so that upstream logic only honours o_hazard_stall.
// PARAMETERS
//  SIZE          32   datapath width
//  NUM_REGISTERS 32   register count; reg 0 hard-wired to 0
//  SIZE_REG_DIR  $clog2(NUM_REGISTERS)  register address width
//  NUM_FWD       3    forwarding sources; index 0 = youngest = highest priority
// PORTS
//  clk               in  1                 clock, rising edge
//  rst               in  1                 async active-high reset
//  i_valid           in  1                 IF/ID holds a real instruction
//  i_instruction     in  SIZE              instruction word
//  i_pc              in  SIZE              PC+4 of the instruction
//  i_stall           in  1                 external stall: ID/EX register holds
//  i_flush           in  1                 load bubble into ID/EX
//  i_write_enable    in  1                 writeback enable
//  i_w_dir           in  SIZE_REG_DIR      writeback address
//  i_w_data          in  SIZE              writeback data
//  i_fwd_rd          in  NUM_FWD*SIZE_REG_DIR  destination per source
//  i_fwd_wr          in  NUM_FWD           source writes a register
//  i_fwd_ready       in  NUM_FWD           source data valid now (0 = load still in flight)
//  i_fwd_data        in  NUM_FWD*SIZE      source data
//  o_hazard_stall    out 1                 comb.; upstream must hold PC and IF/ID
//  o_valid           out 1                 ID/EX valid
//  o_op / o_funct    out 6 / 6             instr[31:26] / instr[5:0]
//  o_reg_A, o_reg_B  out SIZE              forwarded rs/rt values
//  o_immediate       out SIZE              sign-extended instr[15:0]
//  o_dir_rs/rt/rd    out SIZE_REG_DIR      instr[25:21] / [20:16] / [15:11]
//  o_pc              out SIZE              PC+4 passed through
//  o_branch_taken    out 1                 comb.; see CONFIGURATION
//  o_branch_target   out SIZE              comb.; i_pc + (imm<<2)
//  o_registers_debug out SIZE*NUM_REGISTERS  flat register-file image, reg0 at LSBs
// BEHAVIOUR
//  - Reset: all registers, ID/EX fields and o_valid = 0; o_hazard_stall = 0.
//  - Register file: written at posedge when i_write_enable and i_w_dir != 0.
//  - Write-through: a same-cycle read of i_w_dir returns i_w_data.
//  - Operand select, per rs/rt (addr != 0), first match wins:
//    lowest index k with i_fwd_wr[k] && i_fwd_rd[k] == addr, else the register file.
//  - Address 0 always yields 0 and never matches any forwarding source.
//  - Hazard: o_hazard_stall = i_valid && the winning source for rs or rt has
//    i_fwd_ready = 0.
//  - Lower-priority ready sources never override a not-ready winner.
//  - ID/EX register update at posedge, priority order:
//    rst > i_flush (bubble) > i_stall (hold all fields) > o_hazard_stall (bubble)
//    > load decoded fields with o_valid = i_valid.
//  - A bubble clears o_valid, o_op and the dir fields; the data fields are don't-care.
//  - Latency: 1 cycle from IF/ID to ID/EX.
//  - A hazard persists until the source reports ready; stall length equals the wait cycles.
//  - Simultaneous i_stall and hazard: the hold wins; o_hazard_stall is still driven.
//  - Reset mid-stall clears everything; no stall survives reset.
// CONFIGURATION
//  ID_BRANCH_RESOLVE_EN defined:
//  - BEQ (op 000100) / BNE (op 000101) are compared in ID on the forwarded A/B values.
//  - o_branch_taken = i_valid && !o_hazard_stall && !i_stall && condition true.
//  - o_branch_target = i_pc + {imm[SIZE-3:0], 2'b00}.
//  - Branch operands use the same hazard rule as all other operands.
//  ID_BRANCH_RESOLVE_EN undefined:
//  - o_branch_taken = 0 and o_branch_target = 0.
//  - Branches flow to EX as ordinary instructions.
// TESTING
//  - Reset, then write r5 = 0x1234 while decoding a read of r5 in the same cycle
//    -> o_reg_A = 0x1234 the next cycle.
//  - fwd[0] rd=3 data=0xA, fwd[2] rd=3 data=0xB, both ready, read r3
//    -> o_reg_A = 0xA (youngest source wins).
//  - fwd[0] rd=4 wr=1 ready=0, instruction reads rt=r4
//    -> o_hazard_stall = 1, next o_valid = 0.
//    Set ready=1 with data 0x77 -> o_hazard_stall = 0, next o_reg_B = 0x77.
//  - fwd[1] rd=0 wr=1 data=0xFF, instruction reads r0
//    -> o_reg_A = 0 and no stall.
//  - i_stall = 1 for 3 cycles while new instructions arrive
//    -> all ID/EX outputs unchanged.
//    i_flush during the stall -> o_valid = 0.
//  - (ID_BRANCH_RESOLVE_EN) BEQ r1,r2 with r1 = r2 = 7, imm = 4, i_pc = 0x100
//    -> o_branch_taken = 1, o_branch_target = 0x110.
//    The same test with BNE -> o_branch_taken = 0.

Source files
------------

// File: rtl/id_stage_pipelined_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, forwarding sources and ID/EX outputs.
// The slave modport is the decode stage itself; the master modport is whatever drives it.
interface id_stage_pipelined_if #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_FWD       = 3,
  parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS)
);
   logic                            i_valid;
   logic [SIZE-1:0]                 i_instruction;
   logic [SIZE-1:0]                 i_pc;
   logic                            i_stall;
   logic                            i_flush;
   logic                            i_write_enable;
   logic [SIZE_REG_DIR-1:0]         i_w_dir;
   logic [SIZE-1:0]                 i_w_data;
   logic [NUM_FWD*SIZE_REG_DIR-1:0] i_fwd_rd;
   logic [NUM_FWD-1:0]              i_fwd_wr;
   logic [NUM_FWD-1:0]              i_fwd_ready;
   logic [NUM_FWD*SIZE-1:0]         i_fwd_data;
   logic                            o_hazard_stall;
   logic                            o_valid;
   logic [5:0]                      o_op;
   logic [5:0]                      o_funct;
   logic [SIZE-1:0]                 o_reg_A;
   logic [SIZE-1:0]                 o_reg_B;
   logic [SIZE-1:0]                 o_immediate;
   logic [SIZE_REG_DIR-1:0]         o_dir_rs;
   logic [SIZE_REG_DIR-1:0]         o_dir_rt;
   logic [SIZE_REG_DIR-1:0]         o_dir_rd;
   logic [SIZE-1:0]                 o_pc;
   logic                            o_branch_taken;
   logic [SIZE-1:0]                 o_branch_target;
   logic [SIZE*NUM_REGISTERS-1:0]   o_registers_debug;

   modport master (
     output i_valid, i_instruction, i_pc, i_stall, i_flush, i_write_enable, i_w_dir, i_w_data,
            i_fwd_rd, i_fwd_wr, i_fwd_ready, i_fwd_data,
     input  o_hazard_stall, o_valid, o_op, o_funct, o_reg_A, o_reg_B, o_immediate,
            o_dir_rs, o_dir_rt, o_dir_rd, o_pc, o_branch_taken, o_branch_target, o_registers_debug
   );

   modport slave (
     input  i_valid, i_instruction, i_pc, i_stall, i_flush, i_write_enable, i_w_dir, i_w_data,
            i_fwd_rd, i_fwd_wr, i_fwd_ready, i_fwd_data,
     output o_hazard_stall, o_valid, o_op, o_funct, o_reg_A, o_reg_B, o_immediate,
            o_dir_rs, o_dir_rt, o_dir_rd, o_pc, o_branch_taken, o_branch_target, o_registers_debug
   );
endinterface

// File: rtl/id_stage_pipelined.sv
// Decode stage: write-through register file, priority forwarding, load-use stall, ID/EX register.
// Define ID_BRANCH_RESOLVE_EN to resolve BEQ/BNE in this stage.
module id_stage_pipelined #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_FWD       = 3,
  parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS)
) (
  input logic clk,
  input logic rst,
  id_stage_pipelined_if.slave bus
);
   typedef struct packed {
      logic                    valid;
      logic [5:0]              op;
      logic [5:0]              funct;
      logic [SIZE-1:0]         reg_a;
      logic [SIZE-1:0]         reg_b;
      logic [SIZE-1:0]         imm;
      logic [SIZE_REG_DIR-1:0] rs;
      logic [SIZE_REG_DIR-1:0] rt;
      logic [SIZE_REG_DIR-1:0] rd;
      logic [SIZE-1:0]         pc;
   } idex_t;

   logic [SIZE-1:0]         rf_q [NUM_REGISTERS];
   logic [SIZE-1:0]         rf_d [NUM_REGISTERS];
   idex_t                   idex_q, idex_d;
   logic [SIZE_REG_DIR-1:0] rs, rt, rd;
   logic [SIZE-1:0]         imm;
   logic [SIZE-1:0]         rf_a, rf_b, val_a, val_b;
   logic                    hit_a, hit_b, rdy_a, rdy_b;
   logic [SIZE-1:0]         fwd_a, fwd_b;
   logic                    hazard;

   assign rs  = SIZE_REG_DIR'(bus.i_instruction[25:21]);
   assign rt  = SIZE_REG_DIR'(bus.i_instruction[20:16]);
   assign rd  = SIZE_REG_DIR'(bus.i_instruction[15:11]);
   assign imm = {{(SIZE-16){bus.i_instruction[15]}}, bus.i_instruction[15:0]};

   always_comb begin
      rf_d = rf_q;
      if (bus.i_write_enable && bus.i_w_dir != '0) rf_d[bus.i_w_dir] = bus.i_w_data;
   end

   // Write-through: reading the register being written returns the incoming data.
   always_comb begin
      rf_a = '0;
      rf_b = '0;
      if (rs != '0) rf_a = (bus.i_write_enable && bus.i_w_dir == rs) ? bus.i_w_data : rf_q[rs];
      if (rt != '0) rf_b = (bus.i_write_enable && bus.i_w_dir == rt) ? bus.i_w_data : rf_q[rt];
   end

   // Scan from the oldest source down so the youngest match is the one left standing.
   always_comb begin
      hit_a = 1'b0; rdy_a = 1'b1; fwd_a = '0;
      hit_b = 1'b0; rdy_b = 1'b1; fwd_b = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (bus.i_fwd_wr[k] && rs != '0 && bus.i_fwd_rd[k*SIZE_REG_DIR +: SIZE_REG_DIR] == rs) begin
            hit_a = 1'b1;
            rdy_a = bus.i_fwd_ready[k];
            fwd_a = bus.i_fwd_data[k*SIZE +: SIZE];
         end
         if (bus.i_fwd_wr[k] && rt != '0 && bus.i_fwd_rd[k*SIZE_REG_DIR +: SIZE_REG_DIR] == rt) begin
            hit_b = 1'b1;
            rdy_b = bus.i_fwd_ready[k];
            fwd_b = bus.i_fwd_data[k*SIZE +: SIZE];
         end
      end
   end

   assign val_a  = hit_a ? fwd_a : rf_a;
   assign val_b  = hit_b ? fwd_b : rf_b;
   assign hazard = !rst && bus.i_valid && ((hit_a && !rdy_a) || (hit_b && !rdy_b));

   always_comb begin
      idex_d = idex_q;
      if (bus.i_flush) begin
         idex_d = '0;
      end else if (bus.i_stall) begin
         idex_d = idex_q;
      end else if (hazard) begin
         idex_d = '0;
      end else begin
         idex_d.valid = bus.i_valid;
         idex_d.op    = bus.i_instruction[31:26];
         idex_d.funct = bus.i_instruction[5:0];
         idex_d.reg_a = val_a;
         idex_d.reg_b = val_b;
         idex_d.imm   = imm;
         idex_d.rs    = rs;
         idex_d.rt    = rt;
         idex_d.rd    = rd;
         idex_d.pc    = bus.i_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGISTERS; i++) rf_q[i] <= '0;
         idex_q <= '0;
      end else begin
         rf_q   <= rf_d;
         idex_q <= idex_d;
      end
   end

   assign bus.o_hazard_stall = hazard;
   assign bus.o_valid        = idex_q.valid;
   assign bus.o_op           = idex_q.op;
   assign bus.o_funct        = idex_q.funct;
   assign bus.o_reg_A        = idex_q.reg_a;
   assign bus.o_reg_B        = idex_q.reg_b;
   assign bus.o_immediate    = idex_q.imm;
   assign bus.o_dir_rs       = idex_q.rs;
   assign bus.o_dir_rt       = idex_q.rt;
   assign bus.o_dir_rd       = idex_q.rd;
   assign bus.o_pc           = idex_q.pc;

   for (genvar g = 0; g < NUM_REGISTERS; g++) begin : g_dbg
      assign bus.o_registers_debug[g*SIZE +: SIZE] = rf_q[g];
   end

`ifdef ID_BRANCH_RESOLVE_EN
   logic br_cond;
   assign br_cond = (bus.i_instruction[31:26] == 6'b000100 && val_a == val_b) ||
                    (bus.i_instruction[31:26] == 6'b000101 && val_a != val_b);
   assign bus.o_branch_taken  = bus.i_valid && !hazard && !bus.i_stall && br_cond;
   assign bus.o_branch_target = bus.i_pc + {imm[SIZE-3:0], 2'b00};
`else
   assign bus.o_branch_taken  = 1'b0;
   assign bus.o_branch_target = '0;
`endif
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined; branch expectations follow ID_BRANCH_RESOLVE_EN.
module tb_id_stage_pipelined;
  localparam int SIZE = 32;
  localparam int NREG = 32;
  localparam int NFWD = 3;
  localparam int RDW  = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  id_stage_pipelined_if #(.SIZE(SIZE), .NUM_REGISTERS(NREG), .NUM_FWD(NFWD)) bus ();

  id_stage_pipelined #(.SIZE(SIZE), .NUM_REGISTERS(NREG), .NUM_FWD(NFWD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm16);
    return {op, rs, rt, imm16};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_fwd(input int k, input logic [4:0] rd, input logic wr,
                         input logic rdy, input logic [31:0] data);
    bus.i_fwd_rd[k*RDW +: RDW]    = rd;
    bus.i_fwd_wr[k]               = wr;
    bus.i_fwd_ready[k]            = rdy;
    bus.i_fwd_data[k*SIZE +: SIZE] = data;
  endtask

  task automatic clr_fwd();
    bus.i_fwd_rd    = '0;
    bus.i_fwd_wr    = '0;
    bus.i_fwd_ready = '0;
    bus.i_fwd_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dbg(input int r);
    return bus.o_registers_debug[r*SIZE +: SIZE];
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_instruction = '0; bus.i_pc = '0;
    bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    bus.i_write_enable = 1'b0; bus.i_w_dir = '0; bus.i_w_data = '0;
    clr_fwd();
    tick(); tick();

    // reset state
    chk("rst_valid", {31'b0, bus.o_valid}, 32'h0);
    chk("rst_hazard", {31'b0, bus.o_hazard_stall}, 32'h0);
    chk("rst_reg_a", bus.o_reg_A, 32'h0);
    chk("rst_op", {26'b0, bus.o_op}, 32'h0);
    chk("rst_dbg5", dbg(5), 32'h0);
    rst = 1'b0;

    // write-through: write r5 while reading r5
    bus.i_valid = 1'b1;
    bus.i_instruction = mk_i(6'h23, 5'd5, 5'd0, 16'h8004);
    bus.i_pc = 32'h4;
    bus.i_write_enable = 1'b1; bus.i_w_dir = 5'd5; bus.i_w_data = 32'h1234;
    tick();
    bus.i_write_enable = 1'b0;
    chk("wt_reg_a", bus.o_reg_A, 32'h1234);
    chk("wt_valid", {31'b0, bus.o_valid}, 32'h1);
    chk("wt_op", {26'b0, bus.o_op}, 32'h23);
    chk("wt_funct", {26'b0, bus.o_funct}, 32'h04);
    chk("wt_imm", bus.o_immediate, 32'hFFFF_8004);
    chk("wt_rs", {27'b0, bus.o_dir_rs}, 32'd5);
    chk("wt_rd", {27'b0, bus.o_dir_rd}, 32'd16);
    chk("wt_pc", bus.o_pc, 32'h4);
    chk("wt_dbg5", dbg(5), 32'h1234);

    // priority: youngest source wins, rt from register file
    bus.i_instruction = mk_i(6'h00, 5'd3, 5'd5, 16'h0000);
    set_fwd(0, 5'd3, 1'b1, 1'b1, 32'hA);
    set_fwd(2, 5'd3, 1'b1, 1'b1, 32'hB);
    #1;
    chk("prio_no_hazard", {31'b0, bus.o_hazard_stall}, 32'h0);
    tick();
    chk("prio_reg_a", bus.o_reg_A, 32'hA);
    chk("prio_reg_b", bus.o_reg_B, 32'h1234);
    set_fwd(0, 5'd3, 1'b0, 1'b1, 32'hA);
    tick();
    chk("prio_fallback_reg_a", bus.o_reg_A, 32'hB);

    // load-use hazard; ready lower-priority source must not override
    clr_fwd();
    set_fwd(0, 5'd4, 1'b1, 1'b0, 32'h0);
    set_fwd(1, 5'd4, 1'b1, 1'b1, 32'h55);
    bus.i_instruction = mk_i(6'h2B, 5'd0, 5'd4, 16'h0000);
    bus.i_pc = 32'h10;
    #1;
    chk("haz_stall", {31'b0, bus.o_hazard_stall}, 32'h1);
    tick();
    chk("haz_bubble_valid", {31'b0, bus.o_valid}, 32'h0);
    chk("haz_bubble_op", {26'b0, bus.o_op}, 32'h0);
    chk("haz_bubble_rt", {27'b0, bus.o_dir_rt}, 32'h0);
    chk("haz_stall_persist", {31'b0, bus.o_hazard_stall}, 32'h1);
    tick();
    chk("haz_bubble_valid2", {31'b0, bus.o_valid}, 32'h0);
    set_fwd(0, 5'd4, 1'b1, 1'b1, 32'h77);
    #1;
    chk("haz_release", {31'b0, bus.o_hazard_stall}, 32'h0);
    tick();
    chk("haz_reg_b", bus.o_reg_B, 32'h77);
    chk("haz_valid", {31'b0, bus.o_valid}, 32'h1);
    chk("haz_rt", {27'b0, bus.o_dir_rt}, 32'd4);

    // r0 never matches forwarding, even a not-ready source
    clr_fwd();
    set_fwd(1, 5'd0, 1'b1, 1'b0, 32'hFF);
    bus.i_instruction = mk_i(6'h08, 5'd0, 5'd0, 16'h0010);
    bus.i_pc = 32'h20;
    #1;
    chk("r0_no_hazard", {31'b0, bus.o_hazard_stall}, 32'h0);
    tick();
    chk("r0_reg_a", bus.o_reg_A, 32'h0);
    chk("r0_reg_b", bus.o_reg_B, 32'h0);
    chk("r0_op", {26'b0, bus.o_op}, 32'h08);
    clr_fwd();

    // external stall holds ID/EX for three cycles, hazard still reported
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_instruction = mk_i(6'h0F, 5'(i + 1), 5'd2, 16'h1234 + 16'(i));
      bus.i_pc = 32'h30 + 32'(4 * i);
      if (i == 1) set_fwd(0, 5'd2, 1'b1, 1'b0, 32'h0);
      else clr_fwd();
      #1;
      if (i == 1) chk("stall_hazard_driven", {31'b0, bus.o_hazard_stall}, 32'h1);
      tick();
      chk("stall_op", {26'b0, bus.o_op}, 32'h08);
      chk("stall_imm", bus.o_immediate, 32'h10);
      chk("stall_pc", bus.o_pc, 32'h20);
      chk("stall_valid", {31'b0, bus.o_valid}, 32'h1);
    end
    clr_fwd();
    bus.i_flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, bus.o_valid}, 32'h0);
    chk("flush_op", {26'b0, bus.o_op}, 32'h0);
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;

    // register file writes, r0 stays zero
    bus.i_valid = 1'b0;
    bus.i_write_enable = 1'b1; bus.i_w_dir = 5'd1; bus.i_w_data = 32'd7;
    tick();
    bus.i_w_dir = 5'd2;
    tick();
    bus.i_w_dir = 5'd0; bus.i_w_data = 32'hDEAD;
    tick();
    bus.i_write_enable = 1'b0;
    chk("rf_dbg1", dbg(1), 32'd7);
    chk("rf_dbg2", dbg(2), 32'd7);
    chk("rf_dbg0", dbg(0), 32'h0);

    // branch resolve
    bus.i_valid = 1'b1;
    bus.i_instruction = mk_i(6'h04, 5'd1, 5'd2, 16'h0004);
    bus.i_pc = 32'h100;
    #1;
`ifdef ID_BRANCH_RESOLVE_EN
    chk("beq_taken", {31'b0, bus.o_branch_taken}, 32'h1);
    chk("beq_target", bus.o_branch_target, 32'h110);
`else
    chk("beq_taken", {31'b0, bus.o_branch_taken}, 32'h0);
    chk("beq_target", bus.o_branch_target, 32'h0);
`endif
    tick();
    chk("beq_reg_a", bus.o_reg_A, 32'd7);
    chk("beq_reg_b", bus.o_reg_B, 32'd7);
    chk("beq_op", {26'b0, bus.o_op}, 32'h04);
    bus.i_instruction = mk_i(6'h05, 5'd1, 5'd2, 16'h0004);
    #1;
    chk("bne_taken", {31'b0, bus.o_branch_taken}, 32'h0);

    // reset in the middle of a hazard stall
    set_fwd(0, 5'd1, 1'b1, 1'b0, 32'h0);
    bus.i_instruction = mk_i(6'h00, 5'd1, 5'd0, 16'h0000);
    #1;
    chk("pre_rst_hazard", {31'b0, bus.o_hazard_stall}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_hazard", {31'b0, bus.o_hazard_stall}, 32'h0);
    chk("mid_rst_valid", {31'b0, bus.o_valid}, 32'h0);
    chk("mid_rst_dbg1", dbg(1), 32'h0);
    tick();
    rst = 1'b0;
    clr_fwd();
    bus.i_valid = 1'b0;
    chk("post_rst_dbg5", dbg(5), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
